// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor: samples a divided clock as data in the fast clk domain,
// emits registered rise/fall strobes, measures the rise-to-rise period,
// reports lock when periods stay within tolerance and flags a stopped input.
//
// Ports:
//   clk, rst          fast clock, synchronous active-high reset
//   en                monitor enable (0 forces IDLE)
//   clk_in            divided clock, treated as asynchronous data
//   exp_period, tol   expected period and allowed absolute deviation
//   rise_pulse        one-cycle strobe per clk_in rising edge
//   fall_pulse        one-cycle strobe per clk_in falling edge
//   period            last measured rise-to-rise period (clk cycles)
//   period_valid      one-cycle strobe when period updates
//   locked            period in tolerance for LOCK_COUNT consecutive periods
//   stuck             no clk_in edge for STUCK_LIMIT cycles
//   err_count         saturating count of bad periods plus stuck events
module clk_edge_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STUCK_LIMIT = 64,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stuck,
  output logic [7:0]       err_count
);

  localparam int unsigned STREAK_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned PRIME_W  = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {IDLE, ACQ, MEAS, STUCK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d_q;
  logic [PRIME_W-1:0]     prime_q, prime_d;
  logic                   edge_ok;
  logic                   rise_q, fall_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       gap_q, gap_d, gap_inc;
  logic [STREAK_W-1:0]    streak_q, streak_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   locked_q, locked_d;
  logic                   stuck_q, stuck_d;
  logic [7:0]             err_q, err_d;
  logic                   err_inc;
  logic                   rise_pulse_q, rise_pulse_d;
  logic                   fall_pulse_q, fall_pulse_d;
  logic [CNT_W:0]         diff;
  logic                   good;

  assign s       = sync_q[SYNC_STAGES-1];
  // Edges are ignored while priming: s_d still tracks s, so a level present
  // at startup or at enable is never mistaken for an edge.
  assign edge_ok = (state_q != IDLE) && (prime_q == '0);
  assign gap_inc = gap_q + CNT_W'(1);
  assign diff    = (cnt_q >= exp_period) ? {1'b0, cnt_q - exp_period}
                                         : {1'b0, exp_period - cnt_q};
  assign good    = (diff <= {1'b0, tol});

  // Prime window: after reset the chain is empty, so hold off edges until it
  // has filled; on every IDLE->ACQ entry suppress at least one cycle.
  always_comb begin
    prime_d = prime_q;
    if (state_q == IDLE) begin
      prime_d = (prime_q > PRIME_W'(1)) ? prime_q - PRIME_W'(1) : PRIME_W'(1);
    end else if (prime_q != '0) begin
      prime_d = prime_q - PRIME_W'(1);
    end
  end

  // Synchronizer, delay flop, registered edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      prime_q <= PRIME_W'(SYNC_STAGES + 1);
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q   <= s;
      rise_q  <= edge_ok & s & ~s_d_q;
      fall_q  <= edge_ok & ~s & s_d_q;
      prime_q <= prime_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    streak_d       = streak_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    stuck_d        = stuck_q;
    err_d          = err_q;
    err_inc        = 1'b0;
    rise_pulse_d   = 1'b0;
    fall_pulse_d   = 1'b0;

    if (state_q != IDLE) begin
      rise_pulse_d = rise_q;
      fall_pulse_d = fall_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        gap_d    = '0;
        streak_d = '0;
        locked_d = 1'b0;
        stuck_d  = 1'b0;
        if (en) state_d = ACQ;
      end
      ACQ, MEAS: begin
        if (state_q == MEAS && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // An edge in the same cycle the gap would expire takes priority.
        if (rise_q || fall_q) begin
          gap_d = '0;
        end else if (gap_inc == CNT_W'(STUCK_LIMIT)) begin
          gap_d    = gap_inc;
          state_d  = STUCK;
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          err_inc  = 1'b1;
        end else begin
          gap_d = gap_inc;
        end
        if (rise_q) begin
          cnt_d = CNT_W'(1);
          if (state_q == ACQ) begin
            state_d = MEAS;
          end else begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            if (good) begin
              if (streak_q < STREAK_W'(LOCK_COUNT)) streak_d = streak_q + STREAK_W'(1);
              if (streak_d == STREAK_W'(LOCK_COUNT)) locked_d = 1'b1;
            end else begin
              streak_d = '0;
              locked_d = 1'b0;
              err_inc  = 1'b1;
            end
          end
        end
      end
      STUCK: begin
        locked_d = 1'b0;
        if (rise_q || fall_q) begin
          state_d  = ACQ;
          stuck_d  = 1'b0;
          gap_d    = '0;
          streak_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

    // Disable wins over everything except a period report already in flight.
    if (!en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      stuck_d  = 1'b0;
      cnt_d    = '0;
      gap_d    = '0;
      streak_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      gap_q          <= '0;
      streak_q       <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stuck_q        <= 1'b0;
      err_q          <= '0;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      streak_q       <= streak_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stuck_q        <= stuck_d;
      err_q          <= err_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
    end
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;
  assign err_count    = err_q;

endmodule
